// File: rtl/uart_rx_frame_check.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_check
//
// Receive-side UART frame checker. It takes mid-bit samples from the sampler
// after the start bit has been validated. It assembles 5..DATA_WIDTH data
// bits, LSB first, then checks an optional parity bit and one or two stop
// bits. Per-frame status is reported alongside saturating error counters.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   frame_start     1-cycle pulse: start bit validated (aborts any frame)
//   sampled_bit     majority-sampled RX bit
//   edge_cnt        oversampling edge counter from the sampler
//   prescale        oversampling ratio; mid-bit is edge_cnt == prescale/2
//   data_len        data bits per frame, clamped to 5..DATA_WIDTH
//   par_mode        0 none, 1 even, 2 odd, 3 mark, 4 space, 5-7 none
//   stop_bits       0 = one stop bit, 1 = two
//   cnt_clr         synchronous clear of both error counters
//   p_data          received data, unused upper bits zero
//   frame_done      1-cycle pulse at frame end
//   frame_valid     1-cycle pulse with frame_done when the frame is clean
//   par_err         parity mismatch in the last frame
//   stop_err        a stop bit was sampled low in the last frame
//   busy            frame in progress
//   par_err_cnt     saturating count of parity-error frames
//   stop_err_cnt    saturating count of stop-error frames
// ---------------------------------------------------------------------------
module uart_rx_frame_check #(
    parameter int DATA_WIDTH     = 9,
    parameter int PRESCALE_WIDTH = 6,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic                      sampled_bit,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [3:0]                data_len,
    input  logic [2:0]                par_mode,
    input  logic                      stop_bits,
    input  logic                      cnt_clr,
    output logic [DATA_WIDTH-1:0]     p_data,
    output logic                      frame_done,
    output logic                      frame_valid,
    output logic                      par_err,
    output logic                      stop_err,
    output logic                      busy,
    output logic [CNT_WIDTH-1:0]      par_err_cnt,
    output logic [CNT_WIDTH-1:0]      stop_err_cnt
);

    localparam logic [3:0] MAX_LEN = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2} state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   p_data_q;
    logic [3:0]              bit_cnt_q;
    logic [3:0]              len_q;
    logic [2:0]              mode_q;
    logic                    two_stop_q;
    logic                    run_par_q;
    logic                    par_err_q;
    logic                    stop_err_q;
    logic                    busy_q;
    logic                    frame_done_q;
    logic                    frame_valid_q;
    logic [CNT_WIDTH-1:0]    par_cnt_q;
    logic [CNT_WIDTH-1:0]    stop_cnt_q;

    logic                    mid;
    logic                    stop_err_d;
    logic                    end_frame;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        if (len < 4'd5)
            return 4'd5;
        else if (len > MAX_LEN)
            return MAX_LEN;
        else
            return len;
    endfunction

    function automatic logic has_parity(input logic [2:0] mode);
        return (mode >= 3'd1) && (mode <= 3'd4);
    endfunction

    function automatic logic expected_parity(input logic [2:0] mode, input logic run);
        case (mode)
            3'd1:    return run;
            3'd2:    return ~run;
            3'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    assign mid = (edge_cnt == (prescale >> 1));

    // Final stop flag for the current stop-bit strobe. In STOP1 stop_err_q is
    // still clear from frame_start, so the OR form serves both stop states.
    assign stop_err_d = stop_err_q | ~sampled_bit;

    // frame_start overrides a coincident strobe, so it also suppresses the end.
    assign end_frame = mid && !frame_start &&
                       ((state_q == STOP1 && !two_stop_q) || state_q == STOP2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            p_data_q      <= '0;
            bit_cnt_q     <= '0;
            len_q         <= 4'd5;
            mode_q        <= '0;
            two_stop_q    <= 1'b0;
            run_par_q     <= 1'b0;
            par_err_q     <= 1'b0;
            stop_err_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_done_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            if (frame_start) begin
                // Accepted in every state: a new start aborts a frame in flight.
                state_q    <= DATA;
                p_data_q   <= '0;
                bit_cnt_q  <= '0;
                len_q      <= clamp_len(data_len);
                mode_q     <= par_mode;
                two_stop_q <= stop_bits;
                run_par_q  <= 1'b0;
                par_err_q  <= 1'b0;
                stop_err_q <= 1'b0;
                busy_q     <= 1'b1;
            end else if (mid) begin
                case (state_q)
                    DATA: begin
                        for (int i = 0; i < DATA_WIDTH; i++) begin
                            if (bit_cnt_q == 4'(i))
                                p_data_q[i] <= sampled_bit;
                        end
                        run_par_q <= run_par_q ^ sampled_bit;
                        if (bit_cnt_q == len_q - 4'd1)
                            state_q <= has_parity(mode_q) ? PARITY : STOP1;
                        else
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                    PARITY: begin
                        par_err_q <= (sampled_bit != expected_parity(mode_q, run_par_q));
                        state_q   <= STOP1;
                    end
                    STOP1, STOP2: begin
                        stop_err_q <= stop_err_d;
                        if (end_frame) begin
                            state_q       <= IDLE;
                            busy_q        <= 1'b0;
                            frame_done_q  <= 1'b1;
                            frame_valid_q <= !par_err_q && !stop_err_d;
                        end else begin
                            state_q <= STOP2;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Error counters: clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            par_cnt_q  <= '0;
            stop_cnt_q <= '0;
        end else if (end_frame) begin
            if (par_err_q)
                par_cnt_q <= sat_inc(par_cnt_q);
            if (stop_err_d)
                stop_cnt_q <= sat_inc(stop_cnt_q);
        end
    end

    assign p_data       = p_data_q;
    assign frame_done   = frame_done_q;
    assign frame_valid  = frame_valid_q;
    assign par_err      = par_err_q;
    assign stop_err     = stop_err_q;
    assign busy         = busy_q;
    assign par_err_cnt  = par_cnt_q;
    assign stop_err_cnt = stop_cnt_q;

endmodule

// File: doc/uart_rx_frame_check.md
# uart_rx_frame_check

Parametrised receive-side frame checker for the UART RX path. It consumes mid-bit samples from the sampler after start-bit validation and assembles 5..DATA_WIDTH data bits, LSB first. It checks parity in one of five runtime-selectable modes and checks one or two stop bits. It reports per-frame status plus saturating error counters. It replaces the fixed-width even/odd parity check and adds serial parity accumulation, mark/space parity, no-parity mode, stop-bit checking and error statistics.

## Interface
- DATA_WIDTH, 9: maximum data bits per frame (≥5).
- PRESCALE_WIDTH, 6: width of prescale and edge_cnt.
- CNT_WIDTH, 8: width of each error counter.

- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse: start bit validated, the next mid-bit strobe is data bit 0.
- sampled_bit  in  1  current majority-sampled RX bit.
- edge_cnt  in  PRESCALE_WIDTH  oversampling edge counter from the sampler.
- prescale  in  PRESCALE_WIDTH  oversampling ratio.
- data_len  in  4  data bits per frame; latched at frame_start; values <5 are used as 5, values >DATA_WIDTH are used as DATA_WIDTH.
- par_mode  in  3  0 none, 1 even, 2 odd, 3 mark, 4 space, 5-7 none; latched at frame_start.
- stop_bits  in  1  0 = one stop bit, 1 = two; latched at frame_start.
- cnt_clr  in  1  synchronous clear of both counters.
- p_data  out  DATA_WIDTH  received data, bit i = data bit i, bits ≥ data_len are 0.
- frame_done  out  1  one-cycle pulse at frame end, with or without errors.
- frame_valid  out  1  one-cycle pulse coincident with frame_done when par_err=0 and stop_err=0.
- par_err  out  1  parity mismatch in the last frame.
- stop_err  out  1  at least one stop bit sampled 0 in the last frame.
- busy  out  1  high from the cycle after frame_start until frame_done.
- par_err_cnt  out  CNT_WIDTH  frames with parity error, saturating.
- stop_err_cnt  out  CNT_WIDTH  frames with stop error, saturating.

## Operation
- Mid-bit strobe: mid = (edge_cnt == prescale >> 1), combinational. Each strobe cycle consumes exactly one bit.
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2.
  - IDLE: on frame_start, latch configuration, clear p_data, running parity, par_err and stop_err, then go to DATA.
  - DATA: on mid, write sampled_bit to p_data[bit_cnt] and XOR it into the running parity. After bit data_len-1, go to PARITY if the mode is not none, else STOP1.
  - PARITY: on mid, compute the expected bit (even = running parity; odd = ~running parity; mark = 1; space = 0). Set par_err if sampled_bit ≠ expected. Go to STOP1.
  - STOP1: on mid, set stop_err if sampled_bit = 0. Go to STOP2 if stop_bits=1, else end the frame.
  - STOP2: on mid, OR in stop_err (set if sampled_bit = 0) and end the frame.
- End of frame: pulse frame_done for one cycle. Pulse frame_valid too if no error. Return to IDLE. Increment each counter whose error flag is set.
- p_data, par_err and stop_err hold from frame end until the next frame_start.
- frame_start in any non-IDLE state aborts the current frame: no frame_done, no counter update, restart as from IDLE.
- frame_start and mid in the same cycle: frame_start wins and the strobe is ignored.
- Counters saturate at 2^CNT_WIDTH−1. cnt_clr takes priority over a same-cycle increment.

## Timing
- Reset values: p_data=0, frame_done=0, frame_valid=0, par_err=0, stop_err=0, busy=0, both counters 0, FSM=IDLE. Reset asserted mid-frame discards the frame at the next edge.
- All outputs are registered.
- frame_done, frame_valid and the final par_err/stop_err values appear on the edge after the last stop-bit mid cycle (latency 1).
- Counters update on that same edge.
- busy rises on the edge after frame_start and falls with frame_done.
- par_err is valid one edge after the parity mid cycle and stays stable through the stop bits.
- Back-to-back frames: frame_start is legal in the cycle after frame_done.

## Test plan
- 8N1, prescale=8, data 0xA5 (LSB first), stop=1 -> p_data=0x0A5, frame_valid pulse, no errors, counters 0.
- 8E1, data 0x07, parity bit 0 -> par_err=1, frame_done without frame_valid, par_err_cnt=1. Repeat with parity bit 1 -> par_err=0.
- 7O2, data 0x55, correct parity 1, second stop bit 0 -> stop_err=1, par_err=0, stop_err_cnt=1. Repeat with data_len=3 -> handled as 5 bits.
- Mark then space parity on 5-bit data 0x1F: parity bits 1 and 0 pass; 0 and 1 respectively fail.
- CNT_WIDTH=2, five parity-error frames -> par_err_cnt sticks at 3. cnt_clr coincident with the 6th error -> counter 0.
- frame_start during DATA bit 3, then reset asserted during the PARITY state of the restarted frame -> no frame_done. All outputs at reset values the next cycle.
